fc_result_reader: RTL
=====================

# fc_result_reader

Reads the ten signed 8-bit FC2 class scores from SRAM f after `fc2_done` and streams them to the host side over a valid/ready handshake. While streaming, it computes the signed argmax and presents the predicted class once the run completes. It is the read-side counterpart of the FC stage's SRAM f write path and sits between SRAM f and the host or result interface.

## Interface
- `DATA_WIDTH`, 8, bits per score
- `DATA_NUM_PER_SRAM_ADDR`, 4, scores packed per SRAM f word
- `CLASS_NUM`, 10, number of scores per run (occupies words 0..2)
- `clk`  in  1  single clock, rising edge
- `srstn`  in  1  asynchronous, active-low reset
- `fc2_done`  in  1  single-cycle pulse; SRAM f holds valid results
- `sram_raddr_f`  out  10  SRAM f read address (registered)
- `sram_rdata_f`  in  32  SRAM f read data, valid one cycle after address
- `score_valid`  out  1  `score_data`/`score_idx` valid
- `score_ready`  in  1  downstream accepts the score
- `score_data`  out  8  signed score
- `score_idx`  out  4  class index 0..9
- `result_valid`  out  1  argmax available (level)
- `result_class`  out  4  index of maximum score
- `result_score`  out  8  signed maximum score
- `result_ack`  in  1  pulse; releases the result
- `busy`  out  1  high in every state except IDLE and DONE

## Operation
- Packing: score n lives at word n>>2, bits [31-8*(n%4) -: 8], so the most significant byte holds the lowest index. Bytes 2..3 of word 2 are unused and are never streamed.
- States:
  - IDLE: waits for `fc2_done`, then goes to FETCH.
  - FETCH: drives `sram_raddr_f` = word pointer for one cycle, then goes to LATCH.
  - LATCH: captures `sram_rdata_f` into a 32-bit word buffer, then goes to STREAM.
  - STREAM: presents one byte at a time. On each accept (`score_valid && score_ready`), advances the byte and element counters.
    - After the 4th byte of a word, returns to FETCH with the pointer incremented.
    - After element CLASS_NUM-1, goes to DONE.
  - DONE: `result_valid`=1.
    - `result_ack` → IDLE.
    - `fc2_done` → FETCH, starting a new run: pointer and counters cleared, `result_valid` drops the next cycle.
    - `fc2_done` and `result_ack` in the same cycle → FETCH.
- Argmax:
  - The accept of index 0 loads max/class unconditionally.
  - Later accepts update only if score > max, compared as signed 8-bit.
  - Ties keep the lowest index.
  - `result_class`/`result_score` hold their value from DONE until the next run's index-0 accept.
- `fc2_done` in FETCH, LATCH or STREAM is ignored; there is no queueing.
- Handshake:
  - Once `score_valid` is asserted, it and `score_data`/`score_idx` stay stable until accepted.
  - `score_valid` does not depend combinationally on `score_ready`.
- Asynchronous reset mid-run aborts immediately. The next run starts only on a new `fc2_done`.

## Timing
- Reset values:
  - `sram_raddr_f`=0, `score_valid`=0, `score_data`=0, `score_idx`=0
  - `result_valid`=0, `result_class`=0, `result_score`=0, `busy`=0
  - State IDLE.
- `fc2_done` sampled at edge 0: FETCH in cycle 1 with `sram_raddr_f`=0, LATCH in cycle 2, `score_valid` high with idx 0 in cycle 3.
- With `score_ready` held at 1:
  - idx0-3 in cycles 3-6
  - FETCH (addr 1) in cycle 7, LATCH in cycle 8, idx4-7 in cycles 9-12
  - FETCH (addr 2) in cycle 13, LATCH in cycle 14, idx8-9 in cycles 15-16
  - `result_valid`=1 from cycle 17; `busy` is low in cycle 17.
- Each cycle of `score_ready`=0 in STREAM adds exactly one cycle.
- `sram_raddr_f` holds its last value outside FETCH.

## Test plan
- Scores {5,-3,17,0,2,17,-128,127,9,1}, `score_ready`=1 → 10 accepts in cycles 3..16 with correct idx/data; `result_valid` at cycle 17; class 7, score 127.
- Same data, `score_ready` toggling 1,0 per cycle → data and idx stable while stalled; accept order 0..9; class 7; `result_valid` delayed by exactly the number of stall cycles.
- All scores -128 → class 0, score -128. Scores {3,9,9,...} with 9 as the maximum → class 1 (tie keeps the lowest index).
- Second `fc2_done` in cycle 5 of a run → ignored: stream order and result unchanged. `fc2_done` in DONE → `result_valid` drops the next cycle and a new run starts with addr 0.
- `srstn` low during idx 5 → all outputs return to reset values asynchronously. After release, no activity until `fc2_done`; a fresh run then gives the correct result.
- `result_ack` in DONE → IDLE: `result_valid`=0 while `result_class`/`result_score` hold their values. `fc2_done` and `result_ack` in the same cycle in DONE → new run starts.

Source files
------------

// File: rtl/fc_result_reader.sv
// SRAM f class-score reader: streams the ten FC2 scores over valid/ready
// and tracks the signed argmax for the host-side result interface.
module fc_result_reader #(
   parameter int DATA_WIDTH             = 8,
   parameter int DATA_NUM_PER_SRAM_ADDR = 4,
   parameter int CLASS_NUM              = 10
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  fc2_done,
   output logic [9:0]            sram_raddr_f,
   input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_f,
   output logic                  score_valid,
   input  logic                  score_ready,
   output logic [DATA_WIDTH-1:0] score_data,
   output logic [3:0]            score_idx,
   output logic                  result_valid,
   output logic [3:0]            result_class,
   output logic [DATA_WIDTH-1:0] result_score,
   input  logic                  result_ack,
   output logic                  busy
);

   localparam int WORD_W  = DATA_WIDTH * DATA_NUM_PER_SRAM_ADDR;
   localparam int BYTE_CW = $clog2(DATA_NUM_PER_SRAM_ADDR);
   localparam logic [BYTE_CW-1:0] LAST_BYTE =
      BYTE_CW'(DATA_NUM_PER_SRAM_ADDR - 1);
   localparam logic [3:0] LAST_IDX = 4'(CLASS_NUM - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_STREAM,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [9:0]            r_ptr;
   logic [9:0]            r_raddr;
   logic [BYTE_CW-1:0]    r_byte;
   logic [WORD_W-1:0]     r_buf;
   logic                  r_vld;
   logic [DATA_WIDTH-1:0] r_data;
   logic [3:0]            r_idx;
   logic                  r_rvld;
   logic [3:0]            r_cls;
   logic [DATA_WIDTH-1:0] r_max;

   logic w_accept;
   logic w_gt;

   assign w_accept = r_vld & score_ready;
   assign w_gt     = $signed(r_data) > $signed(r_max);

   assign sram_raddr_f = r_raddr;
   assign score_valid  = r_vld;
   assign score_data   = r_data;
   assign score_idx    = r_idx;
   assign result_valid = r_rvld;
   assign result_class = r_cls;
   assign result_score = r_max;
   assign busy = (r_state != S_IDLE) && (r_state != S_DONE);

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_raddr <= '0;
         r_byte  <= '0;
         r_buf   <= '0;
         r_vld   <= 1'b0;
         r_data  <= '0;
         r_idx   <= '0;
         r_rvld  <= 1'b0;
         r_cls   <= '0;
         r_max   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (fc2_done) begin
                  r_state <= S_FETCH;
                  r_ptr   <= '0;
                  r_raddr <= '0;
                  r_byte  <= '0;
                  r_idx   <= '0;
               end
            end
            S_FETCH: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_buf   <= sram_rdata_f;
               r_data  <= sram_rdata_f[WORD_W-1 -: DATA_WIDTH];
               r_vld   <= 1'b1;
               r_state <= S_STREAM;
            end
            S_STREAM: begin
               if (w_accept) begin
                  // index 0 seeds the max; ties keep the earlier class
                  if (r_idx == 4'd0 || w_gt) begin
                     r_max <= r_data;
                     r_cls <= r_idx;
                  end
                  if (r_idx == LAST_IDX) begin
                     r_vld   <= 1'b0;
                     r_rvld  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                     if (r_byte == LAST_BYTE) begin
                        r_vld   <= 1'b0;
                        r_byte  <= '0;
                        r_ptr   <= r_ptr + 10'd1;
                        r_raddr <= r_ptr + 10'd1;
                        r_state <= S_FETCH;
                     end else begin
                        r_byte <= r_byte + BYTE_CW'(1);
                        r_buf  <= {r_buf[WORD_W-DATA_WIDTH-1:0],
                                   {DATA_WIDTH{1'b0}}};
                        r_data <= r_buf[WORD_W-DATA_WIDTH-1 -: DATA_WIDTH];
                     end
                  end
               end
            end
            S_DONE: begin
               if (fc2_done) begin
                  r_rvld  <= 1'b0;
                  r_state <= S_FETCH;
                  r_ptr   <= '0;
                  r_raddr <= '0;
                  r_byte  <= '0;
                  r_idx   <= '0;
               end else if (result_ack) begin
                  r_rvld  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
